// File: rtl/nsum_inverse.sv
// ============================================================================
// Module      : nsum_inverse
// Description : Inverse triangular-sum engine. Given a sum S it finds the
//               largest N with N*(N+1)/2 <= S by repeatedly subtracting
//               1, 2, 3, ... from S, then reports N, the remainder S - T(N)
//               and an exact flag (remainder is zero).
// Options     : NSUM_INV_B2B_EN - when defined, a new sum may be accepted in
//               the DONE cycle, so conversions run back to back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nsum_inverse #(
    parameter int SUM_W = 8,
    parameter int N_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             sum_valid,
    output logic             in_ready,
    output logic [N_W-1:0]   n_out,
    output logic [SUM_W-1:0] rem_out,
    output logic             exact,
    output logic             n_valid
);

    // The step counter needs one extra bit over N so that it can hold N+1,
    // the step that finally fails the comparison.
    localparam int C_K_W   = N_W + 1;
    localparam int C_CMP_W = (SUM_W > C_K_W) ? SUM_W : C_K_W;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [SUM_W-1:0] r_rem;
    logic [C_K_W-1:0] r_k;

    logic [C_CMP_W-1:0] w_rem_ext;
    logic [C_CMP_W-1:0] w_k_ext;
    logic               w_take;
    logic [SUM_W-1:0]   w_rem_next;
    logic               w_accept;

    // Both operands are widened to a common width so the comparison never
    // wraps, whichever of SUM_W and N_W+1 is larger.
    assign w_rem_ext  = C_CMP_W'(r_rem);
    assign w_k_ext    = C_CMP_W'(r_k);
    assign w_take     = (w_rem_ext >= w_k_ext);
    // Only used when w_take holds, so k fits in SUM_W bits and the
    // truncation loses nothing.
    assign w_rem_next = SUM_W'(w_rem_ext - w_k_ext);

`ifdef NSUM_INV_B2B_EN
    assign in_ready = (r_state == C_ST_IDLE) || (r_state == C_ST_DONE);
`else
    assign in_ready = (r_state == C_ST_IDLE);
`endif

    assign w_accept = sum_valid && in_ready;

    // Control FSM and datapath: load S, subtract growing steps, publish result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= C_ST_IDLE;
            r_rem   <= '0;
            r_k     <= '0;
            n_out   <= '0;
            rem_out <= '0;
            exact   <= 1'b0;
            n_valid <= 1'b0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    n_valid <= 1'b0;
                    if (w_accept) begin
                        r_rem   <= sum_in;
                        r_k     <= C_K_W'(1);
                        r_state <= C_ST_RUN;
                    end
                end
                C_ST_RUN: begin
                    if (w_take) begin
                        r_rem <= w_rem_next;
                        r_k   <= r_k + C_K_W'(1);
                    end else begin
                        // The last successful step was k-1, which is N.
                        n_out   <= N_W'(r_k - C_K_W'(1));
                        rem_out <= r_rem;
                        exact   <= (r_rem == '0);
                        n_valid <= 1'b1;
                        r_state <= C_ST_DONE;
                    end
                end
                C_ST_DONE: begin
                    n_valid <= 1'b0;
                    r_state <= C_ST_IDLE;
`ifdef NSUM_INV_B2B_EN
                    // Overlap the next load with the result cycle; the
                    // published outputs are untouched by this.
                    if (w_accept) begin
                        r_rem   <= sum_in;
                        r_k     <= C_K_W'(1);
                        r_state <= C_ST_RUN;
                    end
`endif
                end
                default: begin
                    n_valid <= 1'b0;
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nsum_inverse.sv
// ============================================================================
// Module      : tb_nsum_inverse
// Description : Directed self-checking bench for nsum_inverse with
//               hand-computed expected N, remainder, exact flag and latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nsum_inverse;

    logic       clk;
    logic       reset;
    logic [7:0] sum_in;
    logic       sum_valid;
    logic       in_ready;
    logic [4:0] n_out;
    logic [7:0] rem_out;
    logic       exact;
    logic       n_valid;

    int n_checks;
    int n_pass;

    nsum_inverse #(.SUM_W(8), .N_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .sum_in    (sum_in),
        .sum_valid (sum_valid),
        .in_ready  (in_ready),
        .n_out     (n_out),
        .rem_out   (rem_out),
        .exact     (exact),
        .n_valid   (n_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called #1 after an edge with the DUT idle. The accepting edge is cycle
    // 0; returns the number of edges until n_valid is seen, and flags any
    // cycle in RUN/DONE where in_ready was not low.
    task automatic run_conv(input logic [7:0] s, output int lat,
                            output bit rdy_bad, output bit timeout);
        sum_in    = s;
        sum_valid = 1'b1;
        @(posedge clk); #1;
        sum_valid = 1'b0;
        lat     = 0;
        rdy_bad = 1'b0;
        timeout = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (in_ready !== 1'b0) rdy_bad = 1'b1;
            @(posedge clk); #1;
            if (n_valid === 1'b1) begin
                lat     = i;
                timeout = 1'b0;
                break;
            end
        end
`ifndef NSUM_INV_B2B_EN
        if (in_ready !== 1'b0) rdy_bad = 1'b1;
`endif
    endtask

    task automatic test_reset;
        reset = 1'b1; sum_valid = 1'b0; sum_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++; if (n_out !== 5'd0) $display("FAIL reset_n_out: got %0d expected 0", n_out); else n_pass++;
        n_checks++; if (rem_out !== 8'd0) $display("FAIL reset_rem_out: got %0d expected 0", rem_out); else n_pass++;
        n_checks++; if (exact !== 1'b0) $display("FAIL reset_exact: got %0b expected 0", exact); else n_pass++;
        n_checks++; if (n_valid !== 1'b0) $display("FAIL reset_n_valid: got %0b expected 0", n_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b expected 1", in_ready); else n_pass++;
    endtask

    // One conversion with all results checked, plus pulse width and hold.
    task automatic check_conv(input string name, input logic [7:0] s, input int exp_n,
                              input int exp_rem, input logic exp_exact, input int exp_lat);
        int lat; bit rb; bit to;
        run_conv(s, lat, rb, to);
        n_checks++; if (to || lat != exp_lat) $display("FAIL %s_latency: got %0d (timeout %0b) expected %0d", name, lat, to, exp_lat); else n_pass++;
        n_checks++; if (n_out !== 5'(exp_n)) $display("FAIL %s_n_out: got %0d expected %0d", name, n_out, exp_n); else n_pass++;
        n_checks++; if (rem_out !== 8'(exp_rem)) $display("FAIL %s_rem_out: got %0d expected %0d", name, rem_out, exp_rem); else n_pass++;
        n_checks++; if (exact !== exp_exact) $display("FAIL %s_exact: got %0b expected %0b", name, exact, exp_exact); else n_pass++;
        n_checks++; if (rb) $display("FAIL %s_in_ready_busy: got 1 expected 0", name); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (n_valid !== 1'b0) $display("FAIL %s_pulse_width: got %0b expected 0", name, n_valid); else n_pass++;
        n_checks++; if (n_out !== 5'(exp_n) || rem_out !== 8'(exp_rem)) $display("FAIL %s_hold: got n=%0d rem=%0d expected n=%0d rem=%0d", name, n_out, rem_out, exp_n, exp_rem); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL %s_ready_after: got %0b expected 1", name, in_ready); else n_pass++;
    endtask

    task automatic test_exact_10;   check_conv("s10",  8'd10,  4, 0, 1'b1, 5);  endtask
    task automatic test_inexact_12; check_conv("s12",  8'd12,  4, 2, 1'b0, 5);  endtask
    task automatic test_zero;       check_conv("s0",   8'd0,   0, 0, 1'b1, 1);  endtask
    task automatic test_max;
        check_conv("s255", 8'd255, 22, 2, 1'b0, 23);
        check_conv("s253", 8'd253, 22, 0, 1'b1, 23);
    endtask

    // New sums offered while busy must be ignored (S=21 -> N=6 exact).
    task automatic test_ignore_busy;
        int lat; bit seen;
        sum_in = 8'd21; sum_valid = 1'b1;
        @(posedge clk); #1;
        sum_in = 8'd100;
        lat = 0; seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (n_valid === 1'b1) begin lat = i; seen = 1'b1; break; end
        end
        sum_valid = 1'b0;
        n_checks++; if (!seen || lat != 7) $display("FAIL busy_latency: got %0d expected 7", lat); else n_pass++;
        n_checks++; if (n_out !== 5'd6 || rem_out !== 8'd0 || exact !== 1'b1) $display("FAIL busy_result: got n=%0d rem=%0d ex=%0b expected n=6 rem=0 ex=1", n_out, rem_out, exact); else n_pass++;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (n_valid === 1'b1 || in_ready !== 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen) $display("FAIL busy_no_restart: got activity expected idle"); else n_pass++;
    endtask

    task automatic test_reset_mid;
        bit pulse;
        sum_in = 8'd200; sum_valid = 1'b1;
        @(posedge clk); #1;
        sum_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++; if (n_out !== 5'd0 || rem_out !== 8'd0 || exact !== 1'b0 || n_valid !== 1'b0) $display("FAIL midreset_outputs: got n=%0d rem=%0d ex=%0b v=%0b expected all 0", n_out, rem_out, exact, n_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL midreset_in_ready: got %0b expected 1", in_ready); else n_pass++;
        pulse = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (n_valid === 1'b1) pulse = 1'b1;
        end
        n_checks++; if (pulse) $display("FAIL midreset_no_pulse: got pulse expected none"); else n_pass++;
        // Reset and a valid sum together: the sum is dropped.
        reset = 1'b1; sum_valid = 1'b1; sum_in = 8'd50;
        @(posedge clk); #1;
        reset = 1'b0; sum_valid = 1'b0;
        pulse = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (n_valid === 1'b1 || in_ready !== 1'b1) pulse = 1'b1;
        end
        n_checks++; if (pulse) $display("FAIL reset_wins: got activity expected idle"); else n_pass++;
        check_conv("s6", 8'd6, 3, 0, 1'b1, 4);
    endtask

    // S=3 then S=6 held on sum_valid. Cycle 0 is the first accepting edge.
    task automatic test_back_to_back;
        int acc2; int p1; int p2; int npulse;
        logic [4:0] n1; logic [7:0] r1; logic e1;
        logic [4:0] n2; logic [7:0] r2; logic e2;
`ifdef NSUM_INV_B2B_EN
        int exp_acc2 = 4;
`else
        int exp_acc2 = 5;
`endif
        acc2 = -1; p1 = -1; p2 = -1; npulse = 0;
        n1 = '0; r1 = '0; e1 = 1'b0; n2 = '0; r2 = '0; e2 = 1'b0;
        sum_in = 8'd3; sum_valid = 1'b1;
        @(posedge clk); #1;
        sum_in = 8'd6;
        for (int e = 1; e <= 30; e++) begin
            if (acc2 < 0 && sum_valid && in_ready === 1'b1) acc2 = e;
            @(posedge clk); #1;
            if (acc2 == e) sum_valid = 1'b0;
            if (n_valid === 1'b1) begin
                npulse++;
                if (npulse == 1) begin p1 = e; n1 = n_out; r1 = rem_out; e1 = exact; end
                else if (npulse == 2) begin p2 = e; n2 = n_out; r2 = rem_out; e2 = exact; end
            end
        end
        sum_valid = 1'b0;
        n_checks++; if (p1 != 3) $display("FAIL b2b_pulse1_time: got %0d expected 3", p1); else n_pass++;
        n_checks++; if (n1 !== 5'd2 || r1 !== 8'd0 || e1 !== 1'b1) $display("FAIL b2b_pulse1: got (%0d,%0d,%0b) expected (2,0,1)", n1, r1, e1); else n_pass++;
        n_checks++; if (acc2 != exp_acc2) $display("FAIL b2b_accept2: got %0d expected %0d", acc2, exp_acc2); else n_pass++;
        n_checks++; if (n2 !== 5'd3 || r2 !== 8'd0 || e2 !== 1'b1) $display("FAIL b2b_pulse2: got (%0d,%0d,%0b) expected (3,0,1)", n2, r2, e2); else n_pass++;
        n_checks++; if (p2 != exp_acc2 + 4) $display("FAIL b2b_pulse2_time: got %0d expected %0d", p2, exp_acc2 + 4); else n_pass++;
        n_checks++; if (npulse != 2) $display("FAIL b2b_pulse_count: got %0d expected 2", npulse); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset;
        test_exact_10;
        test_inexact_12;
        test_zero;
        test_max;
        test_ignore_busy;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
